// File: rtl/csi_map_pkg.sv
// Shared constants and types for the CsI hit-map cluster counter:
// map geometry, framing patterns, border mask and FSM state encoding.
package csi_map_pkg;

  localparam int MAPSIZE = 38;
  localparam int W       = MAPSIZE + 1;

  function automatic logic [W-1:0] alt_pat(input int phase);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) p[i] = ((i % 2) == phase);
    return p;
  endfunction

  function automatic logic [W-1:0] col_mask();
    logic [W-1:0] m;
    m = '0;
    for (int i = 2; i <= MAPSIZE - 1; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [W-1:0] HDR_PAT  = alt_pat(0);
  localparam logic [W-1:0] TRL_PAT  = alt_pat(1);
  localparam logic [W-1:0] COL_MASK = col_mask();

  localparam logic [5:0] PAIR_MAX  = 6'(MAPSIZE);
  localparam logic [5:0] PAIR_LAST = 6'(MAPSIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROWS = 2'd1,
    CALC = 2'd2
  } csi_state_e;

endpackage

// File: rtl/csi_quad_count.sv
// Combinational 2x2 bit-quad classifier for one row pair: counts windows with
// one set bit, three set bits and diagonal patterns, plus row hit popcount.
module csi_quad_count
  import csi_map_pkg::*;
(
  input  logic [W-1:0] row_a_i,
  input  logic [W-1:0] row_b_i,
  input  logic         last_i,
  output logic [5:0]   n1_o,
  output logic [5:0]   n3_o,
  output logic [5:0]   nd_o,
  output logic [6:0]   hits_o
);

  logic [2:0] qsum;
  logic       diag;

  always_comb begin
    n1_o   = '0;
    n3_o   = '0;
    nd_o   = '0;
    hits_o = '0;
    qsum   = '0;
    diag   = 1'b0;
    for (int j = 0; j < MAPSIZE; j++) begin
      qsum = 3'(row_a_i[j]) + 3'(row_a_i[j+1]) + 3'(row_b_i[j]) + 3'(row_b_i[j+1]);
      diag = (row_a_i[j] & row_b_i[j+1] & ~row_a_i[j+1] & ~row_b_i[j]) |
             (row_a_i[j+1] & row_b_i[j] & ~row_a_i[j] & ~row_b_i[j+1]);
      n1_o = n1_o + 6'(qsum == 3'd1);
      n3_o = n3_o + 6'(qsum == 3'd3);
      nd_o = nd_o + 6'(diag);
    end
    // row_b is the next pair's row_a, so it only contributes on the final pair
    for (int i = 0; i < W; i++)
      hits_o = hits_o + 7'(row_a_i[i]) + 7'(last_i & row_b_i[i]);
  end

endmodule

// File: rtl/csi_cluster_counter.sv
// Framed row-pair consumer computing hit count and Euler-number cluster count.
// CSI_CLUS_8CONN_EN selects 8-connectivity; default build uses 4-connectivity.
module csi_cluster_counter
  import csi_map_pkg::*;
#(
  parameter int CLUS_THR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W-1:0]      row_a,
  input  logic [W-1:0]      row_b,
  output logic [10:0]       hit_cnt,
  output logic signed [7:0] cluster_cnt,
  output logic              clus_trig,
  output logic              result_valid,
  output logic              frame_err
);

  localparam logic signed [7:0] THR8 = 8'(CLUS_THR);

  csi_state_e        state_q;
  logic [5:0]        pair_cnt_q;
  logic              v1_q;
  logic [5:0]        n1_q, n3_q, nd_q;
  logic [6:0]        hits_q;
  logic [11:0]       s1_q, s3_q, sd_q;
  logic [10:0]       hit_q;
  logic [10:0]       hit_cnt_q;
  logic signed [7:0] cluster_q;
  logic              trig_q, valid_q, err_q;

  logic              is_hdr, is_trl, row_a_on, row_b_on, pair_ok, last_pair;
  logic [W-1:0]      masked_a, masked_b;
  logic [5:0]        n1_d, n3_d, nd_d;
  logic [6:0]        hits_d;
  logic signed [13:0] e4_d;
  logic signed [11:0] clus_d;
  logic signed [7:0]  clus_sat_d;

  assign is_hdr    = (row_a == HDR_PAT) && (row_b == HDR_PAT);
  assign is_trl    = (row_a == TRL_PAT) && (row_b == TRL_PAT);
  assign row_a_on  = (pair_cnt_q >= 6'd2) && (pair_cnt_q <= PAIR_LAST);
  assign row_b_on  = (pair_cnt_q >= 6'd1) && (pair_cnt_q <= PAIR_LAST - 6'd1);
  assign masked_a  = row_a & COL_MASK & {W{row_a_on}};
  assign masked_b  = row_b & COL_MASK & {W{row_b_on}};
  assign last_pair = (pair_cnt_q == PAIR_LAST);
  assign pair_ok   = (state_q == ROWS) && !is_hdr && !is_trl && (pair_cnt_q < PAIR_MAX);

  csi_quad_count u_quad (
    .row_a_i (masked_a),
    .row_b_i (masked_b),
    .last_i  (last_pair),
    .n1_o    (n1_d),
    .n3_o    (n3_d),
    .nd_o    (nd_d),
    .hits_o  (hits_d)
  );

`ifdef CSI_CLUS_8CONN_EN
  assign e4_d = $signed({2'b00, s1_q}) - $signed({2'b00, s3_q}) - $signed({1'b0, sd_q, 1'b0});
`else
  assign e4_d = $signed({2'b00, s1_q}) - $signed({2'b00, s3_q}) + $signed({1'b0, sd_q, 1'b0});
`endif
  assign clus_d = e4_d[13:2];

  always_comb begin
    clus_sat_d = clus_d[7:0];
    if (clus_d > 12'sd127)        clus_sat_d = 8'sd127;
    else if (clus_d < -12'sd128)  clus_sat_d = -8'sd128;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
      v1_q       <= 1'b0;
      n1_q       <= '0;
      n3_q       <= '0;
      nd_q       <= '0;
      hits_q     <= '0;
      s1_q       <= '0;
      s3_q       <= '0;
      sd_q       <= '0;
      hit_q      <= '0;
      hit_cnt_q  <= '0;
      cluster_q  <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      v1_q    <= pair_ok;
      n1_q    <= n1_d;
      n3_q    <= n3_d;
      nd_q    <= nd_d;
      hits_q  <= hits_d;
      if (v1_q) begin
        s1_q  <= s1_q + 12'(n1_q);
        s3_q  <= s3_q + 12'(n3_q);
        sd_q  <= sd_q + 12'(nd_q);
        hit_q <= hit_q + 11'(hits_q);
      end
      case (state_q)
        IDLE: begin
          if (is_hdr) begin
            state_q    <= ROWS;
            pair_cnt_q <= '0;
            s1_q <= '0; s3_q <= '0; sd_q <= '0; hit_q <= '0;
          end
        end
        ROWS: begin
          if (is_hdr) begin
            err_q      <= 1'b1;
            pair_cnt_q <= '0;
            s1_q <= '0; s3_q <= '0; sd_q <= '0; hit_q <= '0;
          end else if (is_trl) begin
            if (pair_cnt_q == PAIR_MAX) begin
              state_q <= CALC;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else if (pair_cnt_q == PAIR_MAX) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            pair_cnt_q <= pair_cnt_q + 6'd1;
          end
        end
        CALC: begin
          // accumulators are complete here: the last pair drained on the trailer edge
          hit_cnt_q <= hit_q;
          cluster_q <= clus_sat_d;
          trig_q    <= (clus_sat_d >= THR8);
          valid_q   <= 1'b1;
          if (e4_d[1:0] != 2'b00) err_q <= 1'b1;
          if (is_hdr) begin
            state_q    <= ROWS;
            pair_cnt_q <= '0;
            s1_q <= '0; s3_q <= '0; sd_q <= '0; hit_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_cnt      = hit_cnt_q;
  assign cluster_cnt  = cluster_q;
  assign clus_trig    = trig_q;
  assign result_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_csi_cluster_counter.sv
// Directed bench for csi_cluster_counter: hand-built hit maps, framing faults,
// mid-frame reset and back-to-back frames with hand-computed expectations.
module tb_csi_cluster_counter;

  localparam int W = 39;
  localparam logic [W-1:0] HDR = 39'h55_5555_5555;
  localparam logic [W-1:0] TRL = 39'h2A_AAAA_AAAA;

`ifdef CSI_CLUS_8CONN_EN
  localparam int DIAG_CLUS = 1;
  localparam int DIAG_TRIG = 0;
`else
  localparam int DIAG_CLUS = 2;
  localparam int DIAG_TRIG = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [W-1:0]      row_a, row_b;
  logic [10:0]       hit_cnt;
  logic signed [7:0] cluster_cnt;
  logic              clus_trig, result_valid, frame_err;

  logic [W-1:0] map [0:38];
  int n_checks = 0;
  int n_fail   = 0;

  csi_cluster_counter dut (
    .clk          (clk),
    .reset        (reset),
    .row_a        (row_a),
    .row_b        (row_b),
    .hit_cnt      (hit_cnt),
    .cluster_cnt  (cluster_cnt),
    .clus_trig    (clus_trig),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b);
    row_a = a;
    row_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int r = 0; r < 39; r++) map[r] = '0;
  endtask

  task automatic hit(input int r, input int c);
    map[r][c] = 1'b1;
  endtask

  task automatic send_pairs(input int n);
    for (int k = 0; k < n; k++) put(map[k], map[k+1]);
  endtask

  // full frame, then check latency, result values, and that outputs hold
  task automatic frame_chk(input string tag, input int e_hit, input int e_clus, input int e_trig);
    put(HDR, HDR);
    send_pairs(38);
    put(TRL, TRL);
    chk({tag, "_early_valid"}, int'(result_valid), 0);
    put('0, '0);
    chk({tag, "_valid"}, int'(result_valid), 1);
    chk({tag, "_err"}, int'(frame_err), 0);
    chk({tag, "_hit"}, int'(hit_cnt), e_hit);
    chk({tag, "_clus"}, int'(cluster_cnt), e_clus);
    chk({tag, "_trig"}, int'(clus_trig), e_trig);
    put('0, '0);
    chk({tag, "_pulse"}, int'(result_valid), 0);
    chk({tag, "_hold"}, int'(hit_cnt), e_hit);
  endtask

  initial begin
    reset = 1'b1;
    row_a = '0;
    row_b = '0;
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", int'(hit_cnt), 0);
    chk("rst_clus", int'(cluster_cnt), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    reset = 1'b0;
    put('0, '0);
    put(TRL, TRL);
    chk("idle_trl_ignored", int'(frame_err), 0);

    clear_map(); hit(10, 10);
    frame_chk("single", 1, 1, 0);

    clear_map(); hit(5, 5); hit(20, 20); hit(30, 12);
    frame_chk("three", 3, 3, 1);

    clear_map(); hit(8, 8); hit(8, 9); hit(9, 8); hit(9, 9);
    frame_chk("block", 4, 1, 0);

    clear_map(); hit(10, 10); hit(11, 11);
    frame_chk("diag", 2, DIAG_CLUS, DIAG_TRIG);

    // short frame: trailer after 20 pairs
    put(HDR, HDR);
    send_pairs(20);
    put(TRL, TRL);
    chk("short_err", int'(frame_err), 1);
    chk("short_valid", int'(result_valid), 0);
    put('0, '0);
    chk("short_err_pulse", int'(frame_err), 0);
    chk("short_no_valid", int'(result_valid), 0);
    chk("short_hold_hit", int'(hit_cnt), 2);
    chk("short_hold_clus", int'(cluster_cnt), DIAG_CLUS);

    // reset at pair 15
    clear_map(); hit(5, 5); hit(20, 20); hit(30, 12);
    put(HDR, HDR);
    send_pairs(15);
    reset = 1'b1;
    put('0, '0);
    chk("mid_rst_hit", int'(hit_cnt), 0);
    chk("mid_rst_clus", int'(cluster_cnt), 0);
    chk("mid_rst_trig", int'(clus_trig), 0);
    reset = 1'b0;
    put('0, '0);
    frame_chk("after_rst", 3, 3, 1);

    clear_map(); hit(0, 5); hit(38, 20); hit(10, 1); hit(15, 38);
    frame_chk("border", 0, 0, 0);

    // too many pairs before trailer
    put(HDR, HDR);
    for (int k = 0; k < 38; k++) put('0, '0);
    chk("long_no_err_yet", int'(frame_err), 0);
    put('0, '0);
    chk("long_err", int'(frame_err), 1);

    // header while in ROWS restarts the frame
    clear_map(); hit(10, 10);
    put(HDR, HDR);
    for (int k = 0; k < 5; k++) put(39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFF);
    put(HDR, HDR);
    chk("rehdr_err", int'(frame_err), 1);
    send_pairs(38);
    put(TRL, TRL);
    put(HDR, HDR);
    chk("rehdr_valid", int'(result_valid), 1);
    chk("rehdr_hit", int'(hit_cnt), 1);
    chk("rehdr_clus", int'(cluster_cnt), 1);

    // back-to-back: that header landed in the CALC cycle
    clear_map(); hit(5, 5); hit(20, 20); hit(30, 12);
    send_pairs(38);
    put(TRL, TRL);
    put('0, '0);
    chk("b2b_valid", int'(result_valid), 1);
    chk("b2b_hit", int'(hit_cnt), 3);
    chk("b2b_clus", int'(cluster_cnt), 3);
    chk("b2b_trig", int'(clus_trig), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
